// File: rtl/microwave_sequencer.sv
// Cooking sequencer: button edge detection, door interlock, magnetron/beeper drive
// and countdown timer control for the microwave front panel.
module microwave_sequencer #(
   parameter int unsigned BEEP_SECONDS = 3
) (
   input  logic       clock,
   input  logic       Nreset,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_closed,
   input  logic       timer_zero,
   input  logic       pgt_1Hz,
   output logic       Nenable,
   output logic       timer_en,
   output logic       timer_clearn,
   output logic       mag_on,
   output logic       beep,
   output logic [1:0] state
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COOK  = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   beep_cnt_q, beep_cnt_d;
   logic               clearn_q, clearn_d;
   logic               startn_q, startn_qq;
   logic               stopn_q, stopn_qq;
   logic               start_ev, stop_ev;

   // Two-flop button pipeline; an event is the falling edge between the stages
   always_ff @(posedge clock or negedge Nreset) begin
      if (!Nreset) begin
         startn_q  <= 1'b1;
         startn_qq <= 1'b1;
         stopn_q   <= 1'b1;
         stopn_qq  <= 1'b1;
      end else begin
         startn_q  <= startn;
         startn_qq <= startn_q;
         stopn_q   <= stopn;
         stopn_qq  <= stopn_q;
      end
   end

   assign start_ev = startn_qq & ~startn_q;
   assign stop_ev  = stopn_qq & ~stopn_q;

   // State register, beep counter and timer clear pulse
   always_ff @(posedge clock or negedge Nreset) begin
      if (!Nreset) begin
         state_q    <= ST_IDLE;
         beep_cnt_q <= '0;
         clearn_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         beep_cnt_q <= beep_cnt_d;
         clearn_q   <= clearn_d;
      end
   end

   // Next-state logic; stop outranks start everywhere
   always_comb begin
      state_d    = state_q;
      beep_cnt_d = beep_cnt_q;
      clearn_d   = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (stop_ev) begin
               clearn_d = 1'b0;
            end else if (start_ev && door_closed && !timer_zero) begin
               state_d = ST_COOK;
            end
         end
         ST_COOK: begin
            if (timer_zero) begin
               state_d    = ST_DONE;
               beep_cnt_d = CNT_W'(BEEP_SECONDS);
            end else if (!door_closed || stop_ev) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (stop_ev) begin
               state_d  = ST_IDLE;
               clearn_d = 1'b0;
            end else if (start_ev && door_closed) begin
               state_d = ST_COOK;
            end
         end
         ST_DONE: begin
            if (stop_ev || !door_closed) begin
               state_d = ST_IDLE;
            end else if (pgt_1Hz) begin
               if (beep_cnt_q != '0) begin
                  beep_cnt_d = beep_cnt_q - CNT_W'(1);
               end
               if (beep_cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore output decode
   always_comb begin
      Nenable  = 1'b1;
      timer_en = 1'b0;
      mag_on   = 1'b0;
      beep     = 1'b0;
      unique case (state_q)
         ST_IDLE:  Nenable = 1'b0;
         ST_COOK: begin
            mag_on   = 1'b1;
            timer_en = 1'b1;
         end
         ST_PAUSE: ;
         ST_DONE:  beep = 1'b1;
         default:  Nenable = 1'b0;
      endcase
   end

   assign timer_clearn = clearn_q;
   assign state        = state_q;

endmodule

// File: tb/tb_microwave_sequencer.sv
// Directed self-checking bench for microwave_sequencer.
`timescale 1ns/1ps
module tb_microwave_sequencer;

   logic       clock = 1'b0;
   logic       Nreset;
   logic       startn, stopn, door_closed, timer_zero, pgt_1Hz;
   logic       Nenable, timer_en, timer_clearn, mag_on, beep;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   microwave_sequencer #(.BEEP_SECONDS(3)) dut (
      .clock        (clock),
      .Nreset       (Nreset),
      .startn       (startn),
      .stopn        (stopn),
      .door_closed  (door_closed),
      .timer_zero   (timer_zero),
      .pgt_1Hz      (pgt_1Hz),
      .Nenable      (Nenable),
      .timer_en     (timer_en),
      .timer_clearn (timer_clearn),
      .mag_on       (mag_on),
      .beep         (beep),
      .state        (state)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge and settle 2 ns past it
   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic press_start();
      startn = 1'b0;
      step();
      startn = 1'b1;
      step();
   endtask

   task automatic press_stop();
      stopn = 1'b0;
      step();
      stopn = 1'b1;
      step();
   endtask

   task automatic press_both();
      startn = 1'b0;
      stopn  = 1'b0;
      step();
      startn = 1'b1;
      stopn  = 1'b1;
      step();
   endtask

   task automatic pulse_1hz();
      pgt_1Hz = 1'b1;
      step();
      pgt_1Hz = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_state"},   32'(state),        32'd0);
      check_eq({tag, "_Nenable"}, 32'(Nenable),      32'd0);
      check_eq({tag, "_timer_en"},32'(timer_en),     32'd0);
      check_eq({tag, "_mag_on"},  32'(mag_on),       32'd0);
      check_eq({tag, "_beep"},    32'(beep),         32'd0);
      check_eq({tag, "_clearn"},  32'(timer_clearn), 32'd1);
   endtask

   initial begin
      Nreset      = 1'b0;
      startn      = 1'b1;
      stopn       = 1'b1;
      door_closed = 1'b1;
      timer_zero  = 1'b0;
      pgt_1Hz     = 1'b0;
      #12;
      check_reset_outputs("por");
      step();
      Nreset = 1'b1;
      step();
      check_reset_outputs("idle");

      // Normal cook: startn held low 4 cycles, one transition after 2 edges
      startn = 1'b0;
      step();
      check_eq("cook_edge1_state", 32'(state), 32'd0);
      step();
      check_eq("cook_edge2_state", 32'(state), 32'd1);
      check_eq("cook_mag_on",      32'(mag_on), 32'd1);
      check_eq("cook_timer_en",    32'(timer_en), 32'd1);
      check_eq("cook_Nenable",     32'(Nenable), 32'd1);
      step();
      step();
      startn = 1'b1;
      step();
      check_eq("cook_held_state",  32'(state), 32'd1);
      timer_zero = 1'b1;
      step();
      timer_zero = 1'b0;
      check_eq("done_state",  32'(state), 32'd3);
      check_eq("done_beep",   32'(beep), 32'd1);
      check_eq("done_mag_on", 32'(mag_on), 32'd0);
      pulse_1hz();
      check_eq("done_p1_state", 32'(state), 32'd3);
      step();
      pulse_1hz();
      check_eq("done_p2_state", 32'(state), 32'd3);
      step();
      pulse_1hz();
      check_eq("done_p3_state",   32'(state), 32'd0);
      check_eq("done_p3_beep",    32'(beep), 32'd0);
      check_eq("done_p3_Nenable", 32'(Nenable), 32'd0);

      // Door interlock
      door_closed = 1'b0;
      press_start();
      check_eq("open_start_state", 32'(state), 32'd0);
      check_eq("open_start_mag",   32'(mag_on), 32'd0);
      door_closed = 1'b1;
      press_start();
      check_eq("closed_start_state", 32'(state), 32'd1);
      door_closed = 1'b0;
      step();
      check_eq("door_open_cook", 32'(state), 32'd2);
      check_eq("door_open_mag",  32'(mag_on), 32'd0);
      press_start();
      check_eq("pause_open_start", 32'(state), 32'd2);
      door_closed = 1'b1;
      press_start();
      check_eq("pause_resume", 32'(state), 32'd1);

      // Stop / clear
      press_stop();
      check_eq("stop_cook_state",  32'(state), 32'd2);
      check_eq("stop_cook_clearn", 32'(timer_clearn), 32'd1);
      stopn = 1'b0;
      step();
      stopn = 1'b1;
      check_eq("stop_pause_pre_state",  32'(state), 32'd2);
      check_eq("stop_pause_pre_clearn", 32'(timer_clearn), 32'd1);
      step();
      check_eq("stop_pause_state",  32'(state), 32'd0);
      check_eq("stop_pause_clearn", 32'(timer_clearn), 32'd0);
      step();
      check_eq("stop_pause_clearn_back", 32'(timer_clearn), 32'd1);
      press_stop();
      check_eq("stop_idle_state",  32'(state), 32'd0);
      check_eq("stop_idle_clearn", 32'(timer_clearn), 32'd0);
      step();
      check_eq("stop_idle_clearn_back", 32'(timer_clearn), 32'd1);

      // Priorities
      press_start();
      check_eq("prio_cook", 32'(state), 32'd1);
      press_stop();
      check_eq("prio_pause", 32'(state), 32'd2);
      press_both();
      check_eq("both_pause_state",  32'(state), 32'd0);
      check_eq("both_pause_clearn", 32'(timer_clearn), 32'd0);
      step();
      press_start();
      check_eq("prio_cook2", 32'(state), 32'd1);
      timer_zero  = 1'b1;
      door_closed = 1'b0;
      step();
      timer_zero  = 1'b0;
      door_closed = 1'b1;
      check_eq("tz_over_door", 32'(state), 32'd3);
      pulse_1hz();
      check_eq("done_door_pre_state", 32'(state), 32'd3);
      check_eq("done_door_pre_beep",  32'(beep), 32'd1);
      door_closed = 1'b0;
      step();
      door_closed = 1'b1;
      check_eq("done_door_state", 32'(state), 32'd0);
      check_eq("done_door_beep",  32'(beep), 32'd0);

      // Start with timer at zero is ignored
      timer_zero = 1'b1;
      press_start();
      check_eq("tz_start_state",    32'(state), 32'd0);
      check_eq("tz_start_timer_en", 32'(timer_en), 32'd0);
      timer_zero = 1'b0;

      // Asynchronous reset mid-cook
      press_start();
      check_eq("rst_pre_state", 32'(state), 32'd1);
      #2;
      Nreset = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      startn = 1'b0;
      step();
      step();
      startn = 1'b1;
      check_reset_outputs("rst_hold");
      Nreset = 1'b1;
      step();
      check_eq("rst_release_state", 32'(state), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/microwave_sequencer.md
# microwave_sequencer

Top-level cooking controller for the microwave. It sequences the keypad/timer datapath: it enables keypad entry via `Nenable` and starts/stops the countdown timer. It drives the magnetron and the end-of-cook beeper, enforces the door interlock, and handles start/stop buttons. It sits between the front-panel buttons, the keypad-entry/1 Hz block, and the seconds countdown timer.

## Interface
- `BEEP_SECONDS`, 3: number of `pgt_1Hz` pulses the beeper stays on in DONE; legal range 1–7.
- `clock`  in  1  system clock, all state on rising edge
- `Nreset`  in  1  asynchronous active-low reset
- `startn`  in  1  start button, active-low, synchronous to `clock`
- `stopn`  in  1  stop/clear button, active-low, synchronous to `clock`
- `door_closed`  in  1  1 = door closed
- `timer_zero`  in  1  countdown timer reads 00:00
- `pgt_1Hz`  in  1  one-clock-wide pulse per second from the keypad/timer block
- `Nenable`  out  1  keypad entry enable to the keypad encoder; 0 = entry allowed
- `timer_en`  out  1  countdown timer decrements on `pgt_1Hz` while 1
- `timer_clearn`  out  1  active-low one-cycle clear to the countdown timer
- `mag_on`  out  1  magnetron drive
- `beep`  out  1  beeper drive
- `state`  out  2  current state: IDLE=00, COOK=01, PAUSE=10, DONE=11

## Operation
- Button events:
  - `startn` and `stopn` each pass through two flops (`_q`, `_qq`), both reset to 1.
  - An event is `_qq & ~_q` (falling edge). It is one cycle wide per press; a held button produces one event.
- State outputs (Moore, decoded from the state register):
  - IDLE: `Nenable`=0, all others 0.
  - COOK: `mag_on`=1, `timer_en`=1, `Nenable`=1.
  - PAUSE: `Nenable`=1, all others 0.
  - DONE: `beep`=1, `Nenable`=1.
- `timer_clearn` is a separate register, normally 1.
- Transitions, highest priority first within each state:
  - IDLE:
    - stop event → stay IDLE, `timer_clearn` low for one cycle.
    - start event & `door_closed` & !`timer_zero` → COOK.
    - Start with door open or timer at zero is ignored.
  - COOK:
    - `timer_zero` → DONE, beep counter loaded with `BEEP_SECONDS`.
    - else !`door_closed` → PAUSE.
    - else stop event → PAUSE.
  - PAUSE:
    - stop event → IDLE, `timer_clearn` low for one cycle.
    - else start event & `door_closed` → COOK.
    - Timer value is retained across the pause.
  - DONE:
    - stop event or !`door_closed` → IDLE, beep cut immediately.
    - else `pgt_1Hz` decrements the beep counter; a pulse while the counter is 1 → IDLE.
- Beep counter: 3 bits, reset 0. It is loaded only on the COOK→DONE transition and does not wrap below 0.
- Simultaneous start and stop events: stop wins in every state.

## Timing
- Reset (`Nreset`=0, asynchronous, any time, including mid-cook):
  - State = IDLE, beep counter = 0, edge flops = 1.
  - Outputs: `Nenable`=0, `timer_en`=0, `mag_on`=0, `beep`=0, `timer_clearn`=1, `state`=00.
  - `mag_on` drops without waiting for a clock.
- Button latency: a press present before edge k gives an event during the cycle after edge k. State and outputs change at edge k+1, i.e. 2 rising edges from press to `mag_on`.
- `timer_zero`, `door_closed` and `pgt_1Hz` are used unregistered. State changes at the first rising edge where they are seen, so there is 1 edge of latency.
- `timer_clearn` goes low at the same edge as the stop-caused transition (or the IDLE self-loop) and returns to 1 at the next edge.
- DONE lasts exactly `BEEP_SECONDS` `pgt_1Hz` pulses. The exit edge is the one that samples the last pulse.

## Test plan
- Reset mid-COOK: put the block in COOK, drop `Nreset` between edges → `mag_on`=0 and `state`=00 immediately. All outputs hold their reset values until release.
- Normal cook:
  - Setup: door closed, `timer_zero`=0, pulse `startn` low for 4 cycles.
  - `state`=01 and `mag_on`=1 exactly 2 edges after the press, with only one transition.
  - Raise `timer_zero` → `state`=11, `beep`=1 at the next edge.
  - After 3 `pgt_1Hz` pulses → `state`=00, `beep`=0, `Nenable`=0.
- Door interlock:
  - Start with door open → stays 00, `mag_on`=0.
  - Open the door during COOK → `state`=10 at the next edge.
  - Start again with the door still open → stays 10.
  - Close the door and press start → 01.
- Stop/clear:
  - Stop in COOK → 10.
  - Second stop → 00 with `timer_clearn`=0 for exactly one cycle.
  - Stop in IDLE → `timer_clearn` pulses once, state stays 00.
- Priorities:
  - Start and stop fall in the same cycle in PAUSE → IDLE.
  - `timer_zero` rises and the door opens in the same cycle in COOK → DONE, not PAUSE.
  - Door opens in DONE → IDLE at the next edge, `beep` cut before its 3 pulses.
- Start with `timer_zero`=1 in IDLE → ignored, `state` stays 00, `timer_en`=0.
